// File: rtl/slugtpu_pkg.sv
// rtl/slugtpu_pkg.sv - shared widths, config record and int8 bounds for the requant stage
package slugtpu_pkg;

    localparam int IN_W    = 32;
    localparam int SCALE_W = 32;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 6;
    localparam int PROD_W  = IN_W + SCALE_W;

    localparam logic signed [OUT_W-1:0] INT8_MIN = -8'sd128;
    localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sd127;

    typedef struct packed {
        logic signed [SCALE_W-1:0] scale;
        logic        [SHIFT_W-1:0] shift;
        logic signed [OUT_W-1:0]   zp;
        logic                      relu;
    } requant_cfg_t;

    localparam requant_cfg_t CFG_RESET = '{
        scale: 32'sd1,
        shift: '0,
        zp:    '0,
        relu:  1'b0
    };

endpackage

// File: rtl/round_shift.sv
// rtl/round_shift.sv - rounding (half toward +inf) arithmetic right shift, one guard bit wider
module round_shift #(
    parameter int W    = 64,
    parameter int SH_W = 6
) (
    input  logic signed [W-1:0]  val_i,
    input  logic        [SH_W-1:0] shift_i,
    output logic signed [W:0]    res_o
);

    logic signed [W:0] ext;
    logic signed [W:0] bias;
    logic signed [W:0] sum;

    always_comb begin
        ext  = {val_i[W-1], val_i};
        bias = '0;
        // Half-LSB bias only exists for a non-zero shift; the extra bit absorbs its carry.
        if (shift_i != '0) begin
            bias = (W+1)'(1) << (shift_i - 1'b1);
        end
        sum   = ext + bias;
        res_o = sum >>> shift_i;
    end

endmodule

// File: rtl/requant.sv
// rtl/requant.sv - 3-stage int32 -> int8 requantizer: scale multiply, rounding shift, zero point, relu, saturate
module requant
    import slugtpu_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_we_i,
    input  logic signed [SCALE_W-1:0] cfg_scale_i,
    input  logic        [SHIFT_W-1:0] cfg_shift_i,
    input  logic signed [OUT_W-1:0]   cfg_zp_i,
    input  logic                      cfg_relu_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic signed [IN_W-1:0]    data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic signed [OUT_W-1:0]   data_o
);

    localparam int R_W = PROD_W + 1;
    localparam int S_W = PROD_W + 2;

    requant_cfg_t cfg_q, cfg_d;
    logic         en;

    logic                      s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic        [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic signed [OUT_W-1:0]   s1_zp_q, s1_zp_d;
    logic                      s1_relu_q, s1_relu_d;

    logic                      s2_valid_q, s2_valid_d;
    logic signed [R_W-1:0]     s2_r_q, s2_r_d;
    logic signed [OUT_W-1:0]   s2_zp_q, s2_zp_d;
    logic                      s2_relu_q, s2_relu_d;

    logic                      out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;

    logic signed [PROD_W-1:0]  mul_a;
    logic signed [PROD_W-1:0]  mul_b;
    logic signed [R_W-1:0]     shifted;
    logic signed [S_W-1:0]     s_val;
    logic signed [S_W-1:0]     zp_ext;
    logic signed [S_W-1:0]     max_ext;
    logic signed [S_W-1:0]     min_ext;
    logic signed [OUT_W-1:0]   sat_val;

    round_shift #(
        .W    (PROD_W),
        .SH_W (SHIFT_W)
    ) u_round_shift (
        .val_i   (s1_prod_q),
        .shift_i (s1_shift_q),
        .res_o   (shifted)
    );

    assign en      = !out_valid_q || ready_i;
    assign ready_o = en;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;

    always_comb begin
        zp_ext  = S_W'(s2_zp_q);
        max_ext = S_W'(INT8_MAX);
        min_ext = S_W'(INT8_MIN);
        s_val   = S_W'(s2_r_q) + zp_ext;
        if (s2_relu_q && (s_val < zp_ext)) begin
            s_val = zp_ext;
        end
        // Clamp on the full-width sum so nothing wraps before saturation.
        if (s_val > max_ext) begin
            sat_val = INT8_MAX;
        end else if (s_val < min_ext) begin
            sat_val = INT8_MIN;
        end else begin
            sat_val = s_val[OUT_W-1:0];
        end
    end

    always_comb begin
        cfg_d       = cfg_q;
        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_shift_d  = s1_shift_q;
        s1_zp_d     = s1_zp_q;
        s1_relu_d   = s1_relu_q;
        s2_valid_d  = s2_valid_q;
        s2_r_d      = s2_r_q;
        s2_zp_d     = s2_zp_q;
        s2_relu_d   = s2_relu_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mul_a       = PROD_W'(data_i);
        mul_b       = PROD_W'(cfg_q.scale);

        if (cfg_we_i) begin
            cfg_d.scale = cfg_scale_i;
            cfg_d.shift = cfg_shift_i;
            cfg_d.zp    = cfg_zp_i;
            cfg_d.relu  = cfg_relu_i;
        end

        // Stage 1 reads the registered config, so a same-cycle write only affects later beats.
        if (en) begin
            s1_valid_d  = valid_i;
            s1_prod_d   = mul_a * mul_b;
            s1_shift_d  = cfg_q.shift;
            s1_zp_d     = cfg_q.zp;
            s1_relu_d   = cfg_q.relu;
            s2_valid_d  = s1_valid_q;
            s2_r_d      = shifted;
            s2_zp_d     = s1_zp_q;
            s2_relu_d   = s1_relu_q;
            out_valid_d = s2_valid_q;
            out_data_d  = sat_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q       <= CFG_RESET;
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_shift_q  <= '0;
            s1_zp_q     <= '0;
            s1_relu_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_r_q      <= '0;
            s2_zp_q     <= '0;
            s2_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cfg_q       <= cfg_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_shift_q  <= s1_shift_d;
            s1_zp_q     <= s1_zp_d;
            s1_relu_q   <= s1_relu_d;
            s2_valid_q  <= s2_valid_d;
            s2_r_q      <= s2_r_d;
            s2_zp_q     <= s2_zp_d;
            s2_relu_q   <= s2_relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_requant.sv
// tb/tb_requant.sv - directed bench for requant with hand-computed expected results
module tb_requant;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               cfg_we_i;
    logic signed [31:0] cfg_scale_i;
    logic        [5:0]  cfg_shift_i;
    logic signed [7:0]  cfg_zp_i;
    logic               cfg_relu_i;
    logic               valid_i;
    logic               ready_o;
    logic signed [31:0] data_i;
    logic               valid_o;
    logic               ready_i;
    logic signed [7:0]  data_o;

    int checks = 0;
    int errors = 0;

    requant dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_scale_i (cfg_scale_i),
        .cfg_shift_i (cfg_shift_i),
        .cfg_zp_i    (cfg_zp_i),
        .cfg_relu_i  (cfg_relu_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic signed [31:0] scale, input logic [5:0] shift,
                             input logic signed [7:0] zp, input logic relu);
        @(negedge clk_i);
        cfg_we_i    = 1'b1;
        cfg_scale_i = scale;
        cfg_shift_i = shift;
        cfg_zp_i    = zp;
        cfg_relu_i  = relu;
        @(posedge clk_i);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    // One beat into an empty pipe; result must appear after exactly the third edge.
    task automatic run_one(input string tag, input logic signed [31:0] d, input logic signed [7:0] exp);
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check({tag, "_lat1"}, 64'(valid_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check({tag, "_lat2"}, 64'(valid_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check({tag, "_valid"}, 64'(valid_o), 64'd1);
        check({tag, "_data"}, 64'(data_o), 64'(exp));
    endtask

    initial begin
        int sent;
        int got;
        int stall_cnt;
        logic signed [7:0] rx [0:15];
        logic signed [7:0] held;

        rst_i = 1'b1; cfg_we_i = 1'b0; cfg_scale_i = '0; cfg_shift_i = '0;
        cfg_zp_i = '0; cfg_relu_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        rst_i = 1'b0;

        run_one("default_cfg", 32'sd42, 8'sd42);

        write_cfg(32'sd1073741824, 6'd30, 8'sd0, 1'b0);
        run_one("ident_pos", 32'sd100, 8'sd100);
        run_one("ident_neg", -32'sd100, -8'sd100);

        write_cfg(32'sd1, 6'd1, 8'sd0, 1'b0);
        run_one("rnd_3", 32'sd3, 8'sd2);
        run_one("rnd_m3", -32'sd3, -8'sd1);
        run_one("rnd_2", 32'sd2, 8'sd1);
        run_one("rnd_m1", -32'sd1, 8'sd0);

        write_cfg(32'sd1, 6'd0, 8'sd0, 1'b0);
        run_one("sat_hi", 32'sd1000, 8'sd127);
        run_one("sat_lo", -32'sd1000, -8'sd128);
        write_cfg(32'sh7FFFFFFF, 6'd0, 8'sd0, 1'b0);
        run_one("sat_big", 32'sh7FFFFFFF, 8'sd127);

        write_cfg(32'sd1, 6'd0, -8'sd5, 1'b1);
        run_one("relu_clamp", -32'sd20, -8'sd5);
        run_one("relu_pass", 32'sd10, 8'sd5);
        write_cfg(32'sd1, 6'd0, -8'sd5, 1'b0);
        run_one("zp_norelu", -32'sd20, -8'sd25);

        // Backpressure: five beats, downstream stalls for cycles 4..7.
        write_cfg(32'sd1, 6'd0, 8'sd0, 1'b0);
        sent = 0; got = 0; stall_cnt = 0; held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk_i);
            ready_i = !(cyc >= 4 && cyc <= 7);
            valid_i = (sent < 5);
            data_i  = 32'(sent + 1);
            #1;
            if (!ready_o) stall_cnt++;
            if (cyc == 4) held = data_o;
            if (cyc == 5) check("bp_ready_low", 64'(ready_o), 64'd0);
            if (cyc == 7) begin
                check("bp_valid_held", 64'(valid_o), 64'd1);
                check("bp_data_held", 64'(data_o), 64'(held));
            end
            if (valid_o && ready_i && got < 16) begin
                rx[got] = data_o;
                got++;
            end
            @(posedge clk_i);
            if (valid_i && ready_o) sent++;
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("bp_count", 64'(got), 64'd5);
        check("bp_stalls", 64'(stall_cnt), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_beat%0d", i), 64'(rx[i]), 64'(i + 1));
        end

        // Config write in the same cycle as a beat: that beat uses the old scale.
        @(negedge clk_i);
        cfg_we_i = 1'b1; cfg_scale_i = 32'sd2; cfg_shift_i = '0; cfg_zp_i = '0; cfg_relu_i = 1'b0;
        valid_i = 1'b1; data_i = 32'sd7;
        @(posedge clk_i);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("race_old_valid", 64'(valid_o), 64'd1);
        check("race_old_data", 64'(data_o), 64'd7);
        @(posedge clk_i);
        @(negedge clk_i);
        check("race_new_valid", 64'(valid_o), 64'd1);
        check("race_new_data", 64'(data_o), 64'd14);

        // Reset with beats in flight.
        valid_i = 1'b1; data_i = 32'sd3;
        @(posedge clk_i);
        @(negedge clk_i);
        data_i = 32'sd4;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("pre_rst_valid", 64'(valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 64'(valid_o), 64'd0);
        check("rst_async_data", 64'(data_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (valid_o) stall_cnt++;
        end
        check("rst_flushed", 64'(stall_cnt), 64'd0);
        run_one("rst_cfg_default", 32'sd9, 8'sd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
